window_fetch: RTL and testbench
===============================

# window_fetch

Pixel-window fetch engine for the Sobel datapath. It sits downstream of the traversal address generator. On each move it takes the new centre read address and the move direction, reads only the pixels that newly enter the 3x3 window from the input-image SRAM, and shifts the retained pixels. It then presents a complete 3x3 window to the gradient stage and signals completion with a one-cycle pulse.

## Interface
Parameters:
- PIX_W, 8, pixel width in bits
- ADDR_W, 8, SRAM address width

Ports:
- clk  in  1  system clock; all logic on posedge
- n_reset  in  1  reset; **synchronous, active-high** (port name is retained for consistency)
- start_fetch  in  1  request; sampled only in IDLE
- direction  in  2  00 = full load, 01 = right, 10 = left, 11 = down one row
- addr_r  in  ADDR_W  SRAM address of the new window centre, i.e. the address after the move
- length  in  12  image row stride; low ADDR_W bits used
- mem_ren  out  1  SRAM read enable
- mem_addr  out  ADDR_W  SRAM read address
- mem_rdata  in  PIX_W  SRAM read data, valid exactly one cycle after mem_ren
- window  out  9*PIX_W  pixel w[r][c] at bit offset (3r+c)*PIX_W; r=0 is the top row, c=0 is the left column
- window_valid  out  1  window holds a consistent 3x3 for the current centre
- busy  out  1  fetch in progress
- fetch_done  out  1  one-cycle pulse when the window is updated

## Operation
- States are IDLE, READ and DONE.
- Let C = addr_r and L = length[ADDR_W-1:0]. All address arithmetic is modulo 2^ADDR_W and wraps silently.
- Pixel address for w[r][c] = C + (r-1)*L + (c-1).
- Reads per direction:
  - 00: all 9 pixels, row-major, N=9.
  - 01: shift columns left (w[r][0]<=w[r][1], w[r][1]<=w[r][2]); fetch column c=2 for r=0,1,2; N=3.
  - 10: shift columns right; fetch column c=0 for r=0,1,2; N=3.
  - 11: shift rows up; fetch row r=2 for c=0,1,2; N=3.
- If window_valid=0 when a 01/10/11 request arrives, the block performs a full load (N=9) instead.
- The shift happens on the clock edge that accepts start_fetch. Read captures overwrite only the vacated slots.
- direction, addr_r and length are registered at acceptance. Input changes during a fetch have no effect.
- start_fetch while not in IDLE is ignored. It is not queued.
- Transitions:
  - IDLE->READ on start_fetch.
  - READ->DONE once the last capture is done (issue counter == N and the capture pipeline is empty).
  - DONE->IDLE unconditionally.
- Reset values:
  - mem_ren=0, mem_addr=0, window=0, window_valid=0, busy=0, fetch_done=0, state=IDLE.
- Reset asserted mid-fetch: reset takes priority on the same edge. Outstanding read data is discarded and the next request must be a full load.

## Timing
- start_fetch is sampled high in IDLE in cycle T.
- mem_ren=1 in cycles T+1 .. T+N. Read k (k=0..N-1) drives its mem_addr in cycle T+1+k.
- mem_rdata for read k is captured at the end of cycle T+2+k.
- busy=1 in cycles T+1 .. T+N+1.
- window_valid=0 in cycles T+1 .. T+N+1 and returns to 1 in T+N+2.
- fetch_done=1 only in cycle T+N+2. The window is final in that cycle.
- Latency from start_fetch to fetch_done: 5 cycles for a move, 11 for a full load.
- Earliest next acceptance is cycle T+N+3, i.e. the first cycle back in IDLE.
- Reads are back-to-back with no gaps. The SRAM has no back-pressure.

## Structure
- Shared package sobel_pkg holds:
  - dir_t enum: DIR_LOAD=00, DIR_RIGHT=01, DIR_LEFT=10, DIR_DOWN=11
  - fetch_state_t
  - PIX_W
  - WIN_PIX=9
- The traversal address generator imports dir_t from the same package.
- One natural sub-module, window_fetch_addr_gen: combinational. It maps (direction, k, C, L) to mem_addr and the target slot index.
- The register file, shift logic and FSM stay in window_fetch.

## Test plan
All scenarios use a memory model that returns mem_rdata = address, with L=16.
- **Full load.** Reset, then start_fetch, dir=00, C=17 at T. Required: reads 0,1,2,16,17,18,32,33,34 in T+1..T+9; fetch_done only at T+11; window = 0,1,2/16,17,18/32,33,34.
- **Right, left, down.** After the full load, dir=01, C=18: reads 3,19,35; fetch_done at T+5; window = 1,2,3/17,18,19/33,34,35. Then dir=10, C=17: reads 0,16,32; window returns to the full-load contents. Then dir=11, C=33: reads 48,49,50; window = 16,17,18/32,33,34/48,49,50.
- **Wrap-around.** Valid window, dir=01, C=255. Required: reads 240, 0, 16.
- **Ignored request and late input change.** start_fetch pulsed during READ, and addr_r changed mid-fetch. Required: no extra reads, a single fetch_done, and addresses derived from the values latched at acceptance.
- **Reset mid-fetch and fallback to full load.** Reset asserted at T+3 of a full load. Required: next cycle all outputs are 0. A following dir=01 request then performs 9 reads.

Source files
------------

// File: rtl/sobel_pkg.sv
// Shared types and constants for the Sobel datapath blocks.
package sobel_pkg;

    localparam int unsigned PIX_W   = 8;
    localparam int unsigned WIN_PIX = 9;

    typedef enum logic [1:0] {
        DIR_LOAD  = 2'b00,
        DIR_RIGHT = 2'b01,
        DIR_LEFT  = 2'b10,
        DIR_DOWN  = 2'b11
    } dir_t;

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StDone
    } fetch_state_t;

endpackage

// File: rtl/window_fetch_addr_gen.sv
// Maps read index k of a fetch to the SRAM address and the window slot it fills.
module window_fetch_addr_gen #(
    parameter int unsigned ADDR_W = 8
) (
    input  sobel_pkg::dir_t    direction,
    input  logic [3:0]         k,
    input  logic [ADDR_W-1:0]  centre,
    input  logic [ADDR_W-1:0]  stride,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [3:0]         slot
);
    import sobel_pkg::*;

    logic [1:0]        row;
    logic [1:0]        col;
    logic [ADDR_W-1:0] row_base;

    always_comb begin
        row = 2'd0;
        col = 2'd0;
        unique case (direction)
            DIR_LOAD: begin
                if (k >= 4'd6) begin
                    row = 2'd2;
                    col = 2'(k - 4'd6);
                end else if (k >= 4'd3) begin
                    row = 2'd1;
                    col = 2'(k - 4'd3);
                end else begin
                    row = 2'd0;
                    col = k[1:0];
                end
            end
            DIR_RIGHT: begin
                row = k[1:0];
                col = 2'd2;
            end
            DIR_LEFT: begin
                row = k[1:0];
                col = 2'd0;
            end
            DIR_DOWN: begin
                row = 2'd2;
                col = k[1:0];
            end
            default: ;
        endcase

        unique case (row)
            2'd0:    row_base = centre - stride;
            2'd2:    row_base = centre + stride;
            default: row_base = centre;
        endcase

        // Column offset is col-1; arithmetic wraps modulo 2^ADDR_W.
        mem_addr = row_base + ADDR_W'(col) - ADDR_W'(1);
        slot     = {2'b00, row} * 4'd3 + {2'b00, col};
    end

endmodule

// File: rtl/window_fetch.sv
// 3x3 pixel-window fetch engine: shifts retained pixels and reads only newly exposed ones.
module window_fetch #(
    parameter int unsigned PIX_W  = 8,
    parameter int unsigned ADDR_W = 8
) (
    input  logic                 clk,
    input  logic                 n_reset,
    input  logic                 start_fetch,
    input  logic [1:0]           direction,
    input  logic [ADDR_W-1:0]    addr_r,
    input  logic [11:0]          length,
    output logic                 mem_ren,
    output logic [ADDR_W-1:0]    mem_addr,
    input  logic [PIX_W-1:0]     mem_rdata,
    output logic [9*PIX_W-1:0]   window,
    output logic                 window_valid,
    output logic                 busy,
    output logic                 fetch_done
);
    import sobel_pkg::*;

    fetch_state_t      state_q, state_d;
    dir_t              dir_q, eff_dir;
    logic [ADDR_W-1:0] centre_q, stride_q;
    logic [3:0]        cnt_q, num_q;
    logic              pend_q;
    logic [3:0]        pend_slot_q;
    logic              valid_q;
    logic [PIX_W-1:0]  win_q [WIN_PIX];

    logic              accept, issue;
    logic [ADDR_W-1:0] gen_addr;
    logic [3:0]        gen_slot;
    logic              unused_length;

    assign unused_length = ^length[11:ADDR_W];

    assign accept  = (state_q == StIdle) && start_fetch;
    assign issue   = (state_q == StRead) && (cnt_q != num_q);
    // Moves need a consistent window to shift; otherwise fall back to a full load.
    assign eff_dir = valid_q ? dir_t'(direction) : DIR_LOAD;

    window_fetch_addr_gen #(
        .ADDR_W(ADDR_W)
    ) u_addr_gen (
        .direction (dir_q),
        .k         (cnt_q),
        .centre    (centre_q),
        .stride    (stride_q),
        .mem_addr  (gen_addr),
        .slot      (gen_slot)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start_fetch) state_d = StRead;
            // Final capture lands on the same edge as this transition.
            StRead:  if (cnt_q == num_q) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (n_reset) begin
            state_q     <= StIdle;
            dir_q       <= DIR_LOAD;
            centre_q    <= '0;
            stride_q    <= '0;
            cnt_q       <= '0;
            num_q       <= '0;
            pend_q      <= 1'b0;
            pend_slot_q <= '0;
            valid_q     <= 1'b0;
            for (int i = 0; i < WIN_PIX; i++) win_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            pend_q      <= issue;
            pend_slot_q <= gen_slot;

            if (accept) begin
                dir_q    <= eff_dir;
                centre_q <= addr_r;
                stride_q <= length[ADDR_W-1:0];
                cnt_q    <= '0;
                num_q    <= (eff_dir == DIR_LOAD) ? 4'd9 : 4'd3;
                valid_q  <= 1'b0;
                unique case (eff_dir)
                    DIR_RIGHT: for (int r = 0; r < 3; r++) begin
                        win_q[3*r]   <= win_q[3*r+1];
                        win_q[3*r+1] <= win_q[3*r+2];
                    end
                    DIR_LEFT: for (int r = 0; r < 3; r++) begin
                        win_q[3*r+2] <= win_q[3*r+1];
                        win_q[3*r+1] <= win_q[3*r];
                    end
                    DIR_DOWN: for (int i = 0; i < 6; i++) win_q[i] <= win_q[i+3];
                    default: ;
                endcase
            end

            if (issue) cnt_q <= cnt_q + 4'd1;
            if (pend_q) win_q[pend_slot_q] <= mem_rdata;
            if ((state_q == StRead) && (cnt_q == num_q)) valid_q <= 1'b1;
        end
    end

    always_comb begin
        window = '0;
        for (int i = 0; i < WIN_PIX; i++) window[i*PIX_W +: PIX_W] = win_q[i];
    end

    assign mem_ren      = issue;
    assign mem_addr     = issue ? gen_addr : '0;
    assign window_valid = valid_q;
    assign busy         = (state_q == StRead);
    assign fetch_done   = (state_q == StDone);

endmodule

// File: tb/tb_window_fetch.sv
// Directed bench for window_fetch; the memory model returns the read address as data.
module tb_window_fetch;
    localparam int unsigned PIX_W  = 8;
    localparam int unsigned ADDR_W = 8;

    logic               clk = 1'b0;
    logic               n_reset;
    logic               start_fetch;
    logic [1:0]         direction;
    logic [ADDR_W-1:0]  addr_r;
    logic [11:0]        length;
    logic               mem_ren;
    logic [ADDR_W-1:0]  mem_addr;
    logic [PIX_W-1:0]   mem_rdata = '0;
    logic [9*PIX_W-1:0] window;
    logic               window_valid;
    logic               busy;
    logic               fetch_done;

    int errors = 0;
    int checks = 0;
    logic [7:0] ea [9];
    logic [7:0] ew [9];

    always #5 clk = ~clk;

    window_fetch #(
        .PIX_W  (PIX_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk          (clk),
        .n_reset      (n_reset),
        .start_fetch  (start_fetch),
        .direction    (direction),
        .addr_r       (addr_r),
        .length       (length),
        .mem_ren      (mem_ren),
        .mem_addr     (mem_addr),
        .mem_rdata    (mem_rdata),
        .window       (window),
        .window_valid (window_valid),
        .busy         (busy),
        .fetch_done   (fetch_done)
    );

    always @(posedge clk) mem_rdata <= mem_ren ? mem_addr : 8'h00;

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [71:0] packw();
        logic [71:0] res;
        for (int i = 0; i < 9; i++) res[i*8 +: 8] = ew[i];
        return res;
    endfunction

    // Issues one request, then checks every cycle up to the first cycle back in IDLE.
    // poke > 0 pulses start_fetch and disturbs the inputs in that cycle of the fetch.
    task automatic run_fetch(input logic [1:0] dir, input logic [7:0] c, input int n,
                             input string tag, input int poke);
        @(negedge clk);
        start_fetch = 1'b1;
        direction   = dir;
        addr_r      = c;
        for (int j = 1; j <= n + 3; j++) begin
            @(negedge clk);
            if (j <= n) begin
                check({tag, "_ren"},   72'(mem_ren),      72'(1));
                check({tag, "_addr"},  72'(mem_addr),     72'(ea[j-1]));
                check({tag, "_busy"},  72'(busy),         72'(1));
                check({tag, "_valid"}, 72'(window_valid), 72'(0));
                check({tag, "_done"},  72'(fetch_done),   72'(0));
            end else if (j == n + 1) begin
                check({tag, "_ren_end"},  72'(mem_ren),      72'(0));
                check({tag, "_busy_end"}, 72'(busy),         72'(1));
                check({tag, "_valid_end"},72'(window_valid), 72'(0));
                check({tag, "_done_end"}, 72'(fetch_done),   72'(0));
            end else if (j == n + 2) begin
                check({tag, "_done_pulse"}, 72'(fetch_done),   72'(1));
                check({tag, "_busy_done"},  72'(busy),         72'(0));
                check({tag, "_valid_done"}, 72'(window_valid), 72'(1));
                check({tag, "_window"},     window,            packw());
            end else begin
                check({tag, "_done_clr"},  72'(fetch_done),   72'(0));
                check({tag, "_ren_idle"},  72'(mem_ren),      72'(0));
                check({tag, "_busy_idle"}, 72'(busy),         72'(0));
                check({tag, "_window_idle"}, window,          packw());
            end
            if (j == 1) start_fetch = 1'b0;
            if (j == poke) begin
                start_fetch = 1'b1;
                addr_r      = 8'd100;
                direction   = 2'b11;
            end
            if (j == poke + 1) start_fetch = 1'b0;
        end
    endtask

    initial begin
        n_reset     = 1'b1;
        start_fetch = 1'b0;
        direction   = 2'b00;
        addr_r      = '0;
        length      = 12'd16;
        repeat (2) @(negedge clk);
        check("rst_ren",    72'(mem_ren),      72'(0));
        check("rst_addr",   72'(mem_addr),     72'(0));
        check("rst_window", window,            72'(0));
        check("rst_valid",  72'(window_valid), 72'(0));
        check("rst_busy",   72'(busy),         72'(0));
        check("rst_done",   72'(fetch_done),   72'(0));
        n_reset = 1'b0;

        ea = '{8'd0, 8'd1, 8'd2, 8'd16, 8'd17, 8'd18, 8'd32, 8'd33, 8'd34};
        ew = ea;
        run_fetch(2'b00, 8'd17, 9, "load", 0);

        ea = '{8'd3, 8'd19, 8'd35, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        ew = '{8'd1, 8'd2, 8'd3, 8'd17, 8'd18, 8'd19, 8'd33, 8'd34, 8'd35};
        run_fetch(2'b01, 8'd18, 3, "right", 0);

        ea = '{8'd0, 8'd16, 8'd32, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        ew = '{8'd0, 8'd1, 8'd2, 8'd16, 8'd17, 8'd18, 8'd32, 8'd33, 8'd34};
        run_fetch(2'b10, 8'd17, 3, "left", 0);

        ea = '{8'd48, 8'd49, 8'd50, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        ew = '{8'd16, 8'd17, 8'd18, 8'd32, 8'd33, 8'd34, 8'd48, 8'd49, 8'd50};
        run_fetch(2'b11, 8'd33, 3, "down", 0);

        ea = '{8'd240, 8'd0, 8'd16, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        ew = '{8'd17, 8'd18, 8'd240, 8'd33, 8'd34, 8'd0, 8'd49, 8'd50, 8'd16};
        run_fetch(2'b01, 8'd255, 3, "wrap", 0);

        ea = '{8'd0, 8'd1, 8'd2, 8'd16, 8'd17, 8'd18, 8'd32, 8'd33, 8'd34};
        ew = ea;
        run_fetch(2'b00, 8'd17, 9, "ignore", 2);

        // Reset lands on the edge ending cycle T+3 of a full load.
        @(negedge clk);
        start_fetch = 1'b1;
        direction   = 2'b00;
        addr_r      = 8'd17;
        for (int j = 1; j <= 3; j++) begin
            @(negedge clk);
            if (j == 1) start_fetch = 1'b0;
            if (j == 3) n_reset = 1'b1;
        end
        @(negedge clk);
        check("mid_rst_ren",    72'(mem_ren),      72'(0));
        check("mid_rst_addr",   72'(mem_addr),     72'(0));
        check("mid_rst_window", window,            72'(0));
        check("mid_rst_valid",  72'(window_valid), 72'(0));
        check("mid_rst_busy",   72'(busy),         72'(0));
        check("mid_rst_done",   72'(fetch_done),   72'(0));
        n_reset = 1'b0;

        ea = '{8'd1, 8'd2, 8'd3, 8'd17, 8'd18, 8'd19, 8'd33, 8'd34, 8'd35};
        ew = ea;
        run_fetch(2'b01, 8'd18, 9, "fallback", 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
